// File: rtl/cnn_stream_loader_pkg.sv
// Shared sizing, mode encodings and loader state type for the CNN front-end loader.
package cnn_pkg;
  localparam int DW       = 8;
  localparam int ROW_W    = 11;
  localparam int ROWS     = 11;
  localparam int N_CONV_W = 27;
  localparam int N_FC_W   = 27;

  localparam int N_W    = N_CONV_W + N_FC_W;
  localparam int WCNT_W = $clog2(N_W + 1);
  localparam int PCNT_W = $clog2(ROW_W);
  localparam int RCNT_W = $clog2(ROWS);
  localparam int CIDX_W = $clog2(N_CONV_W);
  localparam int FIDX_W = $clog2(N_FC_W);

  localparam logic MODE_WEIGHT = 1'b0;
  localparam logic MODE_DATA   = 1'b1;

  typedef enum logic [1:0] {
    W_LOAD = 2'd0,
    DATA   = 2'd1,
    STALL  = 2'd2
  } loader_state_t;
endpackage

// File: rtl/cnn_stream_loader_if.sv
// Byte-stream input channel and row output channel of the CNN loader.
interface cnn_stream_loader_if;
  import cnn_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_mode;
  logic signed [DW-1:0] in_data;

  logic                  row_valid;
  logic                  row_ready;
  logic [ROW_W*DW-1:0]   row_data;
  logic                  row_first;
  logic                  row_last;

  modport master (
    output in_valid, in_mode, in_data, row_ready,
    input  in_ready, row_valid, row_data, row_first, row_last
  );

  modport slave (
    input  in_valid, in_mode, in_data, row_ready,
    output in_ready, row_valid, row_data, row_first, row_last
  );
endinterface

// File: rtl/cnn_row_reg.sv
// One-entry valid/ready output register carrying a row plus frame markers.
module cnn_row_reg #(
  parameter int W = 88
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         first_in,
  input  logic         last_in,
  input  logic [W-1:0] data_in,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         first,
  output logic         last,
  output logic         pop
);
  assign pop = valid & ready;

  // A load on the same edge as a pop wins, so a back-to-back row has no bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      first <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_in;
      first <= first_in;
      last  <= last_in;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/cnn_stream_loader.sv
// Weight/data byte-stream loader feeding rows of pixels to the convolution stage.
// state  | meaning
// W_LOAD | loading weights; next weight byte continues the current load
// DATA   | assembling a row; next weight byte restarts the load at index 0
// STALL  | assembled row waiting for the output register; input stalled
module cnn_stream_loader
  import cnn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  cnn_stream_loader_if.slave     bus,
  output logic [N_CONV_W*DW-1:0] conv_w,
  output logic [N_FC_W*DW-1:0]   fc_w,
  output logic                   weights_loaded,
  output logic                   err_no_wts,
  output logic                   err_wt_ovf,
  output logic                   err_partial,
  input  logic                   err_clr
);
  loader_state_t state, state_nx;

  logic [WCNT_W-1:0] wcnt, widx, wnext;
  logic [PCNT_W-1:0] pcnt;
  logic [RCNT_W-1:0] rcnt;

  logic [ROW_W-1:0][DW-1:0]    asm_q, row_in;
  logic [N_CONV_W-1:0][DW-1:0] conv_q;
  logic [N_FC_W-1:0][DW-1:0]   fc_q;

  logic accept, w_byte, d_byte, reload;
  logic w_write, wt_ovf, no_wts, d_store, partial;
  logic row_done, xfer_now, stall_go, row_load, row_pop;
  logic first_in, last_in;

  assign bus.in_ready = (state != STALL);
  assign accept   = bus.in_valid & bus.in_ready;
  assign w_byte   = accept & (bus.in_mode == MODE_WEIGHT);
  assign d_byte   = accept & (bus.in_mode == MODE_DATA);

  // Any data byte since the last weight byte leaves the FSM outside W_LOAD.
  assign reload   = (state != W_LOAD);
  assign widx     = reload ? '0 : wcnt;
  assign wnext    = widx + WCNT_W'(1);
  assign w_write  = w_byte & (widx < WCNT_W'(N_W));
  assign wt_ovf   = w_byte & ~w_write;
  assign no_wts   = d_byte & ~weights_loaded;
  assign d_store  = d_byte & weights_loaded;
  assign partial  = w_byte & (pcnt != '0);

  assign row_done = d_store & (pcnt == PCNT_W'(ROW_W - 1));
  assign xfer_now = row_done & (~bus.row_valid | row_pop);
  assign stall_go = row_done & ~xfer_now;
  assign row_load = xfer_now | ((state == STALL) & row_pop);
  assign first_in = (rcnt == '0);
  assign last_in  = (rcnt == RCNT_W'(ROWS - 1));

  always_comb begin
    row_in = asm_q;
    if (row_done) row_in[ROW_W-1] = bus.in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= W_LOAD;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      W_LOAD: if (d_byte) state_nx = stall_go ? STALL : DATA;
      DATA: begin
        if (stall_go)    state_nx = STALL;
        else if (w_byte) state_nx = W_LOAD;
      end
      STALL:  if (row_pop) state_nx = DATA;
      default: state_nx = W_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt           <= '0;
      weights_loaded <= 1'b0;
      conv_q         <= '0;
      fc_q           <= '0;
    end else if (w_write) begin
      if (widx < WCNT_W'(N_CONV_W)) conv_q[CIDX_W'(widx)] <= bus.in_data;
      else fc_q[FIDX_W'(widx - WCNT_W'(N_CONV_W))] <= bus.in_data;
      wcnt           <= wnext;
      weights_loaded <= (wnext == WCNT_W'(N_W));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt  <= '0;
      rcnt  <= '0;
      asm_q <= '0;
    end else begin
      if (d_store) asm_q[pcnt] <= bus.in_data;
      if (partial || row_done) pcnt <= '0;
      else if (d_store)        pcnt <= pcnt + PCNT_W'(1);
      if (partial)       rcnt <= '0;
      else if (row_load) rcnt <= last_in ? '0 : rcnt + RCNT_W'(1);
    end
  end

  // A new error event on the clearing edge keeps its flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_no_wts  <= 1'b0;
      err_wt_ovf  <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      err_no_wts  <= (err_no_wts  & ~err_clr) | no_wts;
      err_wt_ovf  <= (err_wt_ovf  & ~err_clr) | wt_ovf;
      err_partial <= (err_partial & ~err_clr) | partial;
    end
  end

  assign conv_w = conv_q;
  assign fc_w   = fc_q;

  cnn_row_reg #(.W(ROW_W * DW)) u_row_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (row_load),
    .first_in (first_in),
    .last_in  (last_in),
    .data_in  (row_in),
    .ready    (bus.row_ready),
    .valid    (bus.row_valid),
    .data     (bus.row_data),
    .first    (bus.row_first),
    .last     (bus.row_last),
    .pop      (row_pop)
  );
endmodule

// File: tb/tb_cnn_stream_loader.sv
// Randomized and directed bench for cnn_stream_loader against a queue-based reference model.
module tb_cnn_stream_loader;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err_clr;
  logic [N_CONV_W*DW-1:0] conv_w;
  logic [N_FC_W*DW-1:0]   fc_w;
  logic weights_loaded, err_no_wts, err_wt_ovf, err_partial;

  int n_checks = 0;
  int n_errors = 0;

  cnn_stream_loader_if bus();

  cnn_stream_loader dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .conv_w         (conv_w),
    .fc_w           (fc_w),
    .weights_loaded (weights_loaded),
    .err_no_wts     (err_no_wts),
    .err_wt_ovf     (err_wt_ovf),
    .err_partial    (err_partial),
    .err_clr        (err_clr)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [7:0] m_conv [N_CONV_W];
  logic [7:0] m_fc   [N_FC_W];
  logic [7:0] m_pix  [$];
  logic [7:0] m_hold [ROW_W];
  logic [7:0] m_row  [ROW_W];
  int m_wcnt, m_rowi;
  bit m_loaded, m_reload, m_full, m_rv, m_first, m_last;
  bit m_e_no, m_e_ovf, m_e_part;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_CONV_W; k++) m_conv[k] = 8'h00;
    for (int k = 0; k < N_FC_W; k++)   m_fc[k]   = 8'h00;
    for (int k = 0; k < ROW_W; k++)    m_row[k]  = 8'h00;
    m_pix.delete();
    m_wcnt = 0; m_rowi = 0;
    m_loaded = 0; m_reload = 0; m_full = 0; m_rv = 0; m_first = 0; m_last = 0;
    m_e_no = 0; m_e_ovf = 0; m_e_part = 0;
  endtask

  task automatic present_hold();
    for (int k = 0; k < ROW_W; k++) m_row[k] = m_hold[k];
    m_first = (m_rowi == 0);
    m_last  = (m_rowi == ROWS - 1);
    m_rowi  = (m_rowi + 1) % ROWS;
  endtask

  task automatic model_update(input bit v, input bit mode, input logic [7:0] d,
                              input bit rr, input bit clr);
    bit acc, pop, nv, ev_no, ev_ovf, ev_part;
    acc = v && !m_full;
    pop = m_rv && rr;
    nv  = m_rv && !pop;
    ev_no = 0; ev_ovf = 0; ev_part = 0;
    if (m_full && pop) begin
      present_hold();
      m_full = 0;
      nv = 1;
    end
    if (acc && mode == MODE_WEIGHT) begin
      if (m_pix.size() != 0) begin
        m_pix.delete();
        m_rowi = 0;
        ev_part = 1;
      end
      if (m_reload) begin
        m_reload = 0;
        m_wcnt = 0;
      end
      if (m_wcnt < N_W) begin
        if (m_wcnt < N_CONV_W) m_conv[m_wcnt] = d;
        else m_fc[m_wcnt - N_CONV_W] = d;
        m_wcnt++;
        m_loaded = (m_wcnt == N_W);
      end else begin
        ev_ovf = 1;
      end
    end
    if (acc && mode == MODE_DATA) begin
      m_reload = 1;
      if (!m_loaded) ev_no = 1;
      else begin
        m_pix.push_back(d);
        if (m_pix.size() == ROW_W) begin
          for (int k = 0; k < ROW_W; k++) m_hold[k] = m_pix[k];
          m_pix.delete();
          if (!m_rv || pop) begin
            present_hold();
            nv = 1;
          end else begin
            m_full = 1;
          end
        end
      end
    end
    m_rv = nv;
    m_e_no   = (m_e_no   && !clr) || ev_no;
    m_e_ovf  = (m_e_ovf  && !clr) || ev_ovf;
    m_e_part = (m_e_part && !clr) || ev_part;
  endtask

  task automatic compare_all();
    logic [N_CONV_W*DW-1:0] ec;
    logic [N_FC_W*DW-1:0]   ef;
    logic [ROW_W*DW-1:0]    er;
    for (int k = 0; k < N_CONV_W; k++) ec[k*DW +: DW] = m_conv[k];
    for (int k = 0; k < N_FC_W; k++)   ef[k*DW +: DW] = m_fc[k];
    for (int k = 0; k < ROW_W; k++)    er[k*DW +: DW] = m_row[k];
    chk("in_ready", bus.in_ready, !m_full);
    chk("row_valid", bus.row_valid, m_rv);
    if (m_rv) begin
      chk("row_data", bus.row_data, er);
      chk("row_first", bus.row_first, m_first);
      chk("row_last", bus.row_last, m_last);
    end
    chk("weights_loaded", weights_loaded, m_loaded);
    chk("conv_w", conv_w, ec);
    chk("fc_w", fc_w, ef);
    chk("err_no_wts", err_no_wts, m_e_no);
    chk("err_wt_ovf", err_wt_ovf, m_e_ovf);
    chk("err_partial", err_partial, m_e_part);
  endtask

  // Called just after a falling edge: drive, predict, clock, then compare.
  task automatic step(input bit v, input bit mode, input logic [7:0] d,
                      input bit rr, input bit clr);
    bus.in_valid  = v;
    bus.in_mode   = mode;
    bus.in_data   = d;
    bus.row_ready = rr;
    err_clr       = clr;
    #1;
    chk("in_ready_pre", bus.in_ready, !m_full);
    model_update(v, mode, d, rr, clr);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic load_weights(input bit rand_vals);
    for (int k = 0; k < N_W; k++)
      step(1'b1, MODE_WEIGHT, rand_vals ? 8'($urandom) : 8'(k + 1), 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0; bus.in_mode = 0; bus.in_data = '0; bus.row_ready = 0; err_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b1;

    // data before weights
    for (int i = 0; i < 5; i++) step(1'b1, MODE_DATA, 8'(i), 1'b1, 1'b0);
    chk("no_wts_set", err_no_wts, 1'b1);
    chk("no_wts_novalid", bus.row_valid, 1'b0);
    step(1'b0, MODE_DATA, 8'h00, 1'b1, 1'b1);
    chk("no_wts_clr", err_no_wts, 1'b0);

    // weight load 1..54 plus overflow byte
    load_weights(1'b0);
    chk("wl_after_54", weights_loaded, 1'b1);
    chk("conv_w0", conv_w[7:0], 8'd1);
    chk("fc_w26", fc_w[26*DW +: DW], 8'd54);
    step(1'b1, MODE_WEIGHT, 8'h55, 1'b1, 1'b0);
    chk("wt_ovf", err_wt_ovf, 1'b1);

    // full frame plus one wrapped row
    for (int r = 0; r < ROWS + 1; r++)
      for (int c = 0; c < ROW_W; c++) begin
        step(1'b1, MODE_DATA, 8'(((r % ROWS) * ROW_W + c) % 128), 1'b1, 1'b0);
        if (c == ROW_W - 1) begin
          chk("frame_valid", bus.row_valid, 1'b1);
          chk("frame_first", bus.row_first, (r % ROWS) == 0);
          chk("frame_last", bus.row_last, (r % ROWS) == ROWS - 1);
        end
      end
    step(1'b0, MODE_DATA, 8'h00, 1'b1, 1'b0);

    // backpressure across two rows
    for (int i = 0; i < 2 * ROW_W; i++) step(1'b1, MODE_DATA, 8'($urandom), 1'b0, 1'b0);
    chk("bp_in_ready_low", bus.in_ready, 1'b0);
    step(1'b0, MODE_DATA, 8'h00, 1'b1, 1'b0);
    chk("bp_valid_kept", bus.row_valid, 1'b1);
    chk("bp_in_ready_back", bus.in_ready, 1'b1);
    step(1'b0, MODE_DATA, 8'h00, 1'b1, 1'b0);

    // mode switch mid-row
    for (int i = 0; i < 6; i++) step(1'b1, MODE_DATA, 8'($urandom), 1'b1, 1'b0);
    step(1'b1, MODE_WEIGHT, 8'h7F, 1'b1, 1'b0);
    chk("ms_partial", err_partial, 1'b1);
    chk("ms_wl", weights_loaded, 1'b0);
    chk("ms_conv0", conv_w[7:0], 8'h7F);
    for (int k = 1; k < N_W; k++) step(1'b1, MODE_WEIGHT, 8'($urandom), 1'b1, 1'b0);
    for (int c = 0; c < ROW_W; c++) step(1'b1, MODE_DATA, 8'($urandom), 1'b1, 1'b0);
    chk("ms_rcnt_first", bus.row_first, 1'b1);

    // randomized bursts
    for (int it = 0; it < 60; it++) begin
      int sel = (it == 0) ? 0 : int'($urandom_range(0, 9));
      if (sel == 0) begin
        for (int k = 0; k < N_W + int'($urandom_range(0, 1)); k++)
          step(1'b1, MODE_WEIGHT, 8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
      end else if (sel == 1) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++)
          step(1'b1, MODE_WEIGHT, 8'($urandom), 1'b1, ($urandom_range(0, 9) == 0));
      end else begin
        for (int k = 0; k < int'($urandom_range(1, 40)); k++)
          step(($urandom_range(0, 3) != 0), MODE_DATA, 8'($urandom),
               ($urandom_range(0, 4) < 3), ($urandom_range(0, 29) == 0));
      end
    end

    // asynchronous reset mid-row
    load_weights(1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, MODE_DATA, 8'($urandom), 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("ar_in_ready", bus.in_ready, 1'b1);
    chk("ar_row_valid", bus.row_valid, 1'b0);
    chk("ar_row_data", bus.row_data, '0);
    chk("ar_first_last", {bus.row_first, bus.row_last}, 2'b00);
    chk("ar_wl", weights_loaded, 1'b0);
    chk("ar_conv_w", conv_w, '0);
    chk("ar_fc_w", fc_w, '0);
    chk("ar_errs", {err_no_wts, err_wt_ovf, err_partial}, 3'b000);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    compare_all();
    for (int i = 0; i < 3; i++) step(1'b1, MODE_DATA, 8'($urandom), 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
